// File: rtl/mtimer_responder_pkg.sv
// Shared definitions for the machine-timer responder: word indices of the
// register map, CTRL bit positions and the bus-handshake FSM encoding.
package mtimer_responder_pkg;

    localparam logic [2:0] MTIMER_MTIME_LO = 3'd0;
    localparam logic [2:0] MTIMER_MTIME_HI = 3'd1;
    localparam logic [2:0] MTIMER_CMP_LO   = 3'd2;
    localparam logic [2:0] MTIMER_CMP_HI   = 3'd3;
    localparam logic [2:0] MTIMER_CTRL     = 3'd4;
    localparam logic [2:0] MTIMER_STATUS   = 3'd5;
    localparam logic [2:0] MTIMER_PRESCALE = 3'd6;
    localparam logic [2:0] MTIMER_RESERVED = 3'd7;

    localparam int CTRL_RUN_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } mtimer_state_t;

endpackage

// File: rtl/mtimer_responder_if.sv
// Responder bus between the CPU/mmapper (master) and the timer (slave).
// Requests are levels held until ready; ready is a one-cycle strobe.
interface mtimer_responder_if;

    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    logic [31:0] spo;
    logic        ready;

    modport master (output a, d, we, rd, input spo, ready);
    modport slave  (input a, d, we, rd, output spo, ready);

endinterface

// File: rtl/mtimer_responder_prescaler.sv
// Prescale counter for the machine timer: counts 0..prescale while run is
// high and flags a tick on the cycle the count equals prescale.
module mtimer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        clear,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] count;

    assign tick = (count == prescale);

    // Count up while running, wrap on the terminal value, restart on a reprogram.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 16'd0;
        end else if (run) begin
            count <= tick ? 16'd0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/mtimer_responder.sv
// Memory-mapped machine timer (64-bit mtime / mtimecmp) with a registered
// ready handshake. Optional feature macro: MTIMER_PRESCALE_EN adds the
// PRESCALE register at word 6 and a tick prescaler; without it mtime ticks
// every cycle while running and word 6 reads as zero.
module mtimer_responder
    import mtimer_responder_pkg::*;
#(
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    mtimer_responder_if.slave    bus,
    output logic                 irq
);

    mtimer_state_t state;
    mtimer_state_t next_state;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow_hi;
    logic [31:0] spo_q;
    logic [31:0] read_data;
    logic        run;
    logic        irq_en;
    logic        wr_en;
    logic        rd_en;
    logic        access_en;
    logic        tick;
    logic        cmp_ge;

`ifdef MTIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic        prescale_wr;

    assign prescale_wr = wr_en && (bus.a == MTIMER_PRESCALE);

    mtimer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clear    (prescale_wr),
        .prescale (prescale),
        .tick     (tick)
    );

    // PRESCALE register, written only from the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= 16'd0;
        end else if (prescale_wr) begin
            prescale <= bus.d[15:0];
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign cmp_ge    = (mtime >= mtimecmp);
    assign bus.spo   = spo_q;
    assign bus.ready = (state == ST_RESP);

    // Handshake FSM: accept in IDLE, strobe ready once, wait for the request to drop.
    always_comb begin
        next_state = state;
        access_en  = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.we || bus.rd) begin
                    access_en  = 1'b1;
                    wr_en      = bus.we;
                    rd_en      = bus.rd && !bus.we;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: next_state = ST_HOLD;
            ST_HOLD: begin
                if (!bus.we && !bus.rd) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Register-map read multiplexer.
    always_comb begin
        read_data = 32'd0;
        case (bus.a)
            MTIMER_MTIME_LO: read_data = mtime[31:0];
            MTIMER_MTIME_HI: read_data = shadow_hi;
            MTIMER_CMP_LO:   read_data = mtimecmp[31:0];
            MTIMER_CMP_HI:   read_data = mtimecmp[63:32];
            MTIMER_CTRL:     read_data = {30'd0, irq_en, run};
            MTIMER_STATUS:   read_data = {31'd0, cmp_ge};
`ifdef MTIMER_PRESCALE_EN
            MTIMER_PRESCALE: read_data = {16'd0, prescale};
`endif
            default:         read_data = 32'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture response data when a request is accepted; writes answer with zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            spo_q <= 32'd0;
        end else if (access_en) begin
            spo_q <= wr_en ? 32'd0 : read_data;
        end
    end

    // Latch the upper half on a low-half read so a LO-then-HI pair is coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_hi <= 32'd0;
        end else if (rd_en && (bus.a == MTIMER_MTIME_LO)) begin
            shadow_hi <= mtime[63:32];
        end
    end

    // Free-running counter; a bus write to either half overrides that cycle's tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= 64'd0;
        end else if (wr_en && (bus.a == MTIMER_MTIME_LO)) begin
            mtime[31:0] <= bus.d;
        end else if (wr_en && (bus.a == MTIMER_MTIME_HI)) begin
            mtime[63:32] <= bus.d;
        end else if (run && tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Compare register, written one half at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= CMP_RESET;
        end else if (wr_en && (bus.a == MTIMER_CMP_LO)) begin
            mtimecmp[31:0] <= bus.d;
        end else if (wr_en && (bus.a == MTIMER_CMP_HI)) begin
            mtimecmp[63:32] <= bus.d;
        end
    end

    // Control bits: run enables counting, irq_en gates the interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            run    <= 1'b0;
            irq_en <= 1'b0;
        end else if (wr_en && (bus.a == MTIMER_CTRL)) begin
            run    <= bus.d[CTRL_RUN_BIT];
            irq_en <= bus.d[CTRL_IRQ_EN_BIT];
        end
    end

    // Registered level interrupt from the current-cycle compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= run && irq_en && cmp_ge;
        end
    end

endmodule

// File: tb/tb_mtimer_responder.sv
// Self-checking bench for mtimer_responder: directed bus transactions push
// their expected spo into a queue; a monitor pops and compares on each ready.
// Build with MTIMER_PRESCALE_EN defined to exercise the prescaler section.
module tb_mtimer_responder;
    import mtimer_responder_pkg::*;

    logic clk;
    logic rst;
    logic irq;

    mtimer_responder_if bus_if ();

    mtimer_responder #(
        .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .irq (irq)
    );

    int          checks      = 0;
    int          fails       = 0;
    int          ready_count = 0;
    logic        irq_at_ready;
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One complete bus transaction; called at a negedge, returns at a negedge
    // once the FSM is back in IDLE.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data,
                                 input logic w, input logic r, input logic [31:0] exp_spo);
        int lat;
        bus_if.a  = addr;
        bus_if.d  = data;
        bus_if.we = w;
        bus_if.rd = r;
        exp_q.push_back(exp_spo);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus_if.ready) break;
        end
        if (!bus_if.ready) begin
            checkOutput("ready_timeout", 64'd0, 64'd1);
            void'(exp_q.pop_back());
        end else begin
            checkOutput("latency", 64'(lat), 64'd1);
        end
        irq_at_ready = irq;
        bus_if.we = 1'b0;
        bus_if.rd = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: every ready strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (bus_if.ready) begin
            ready_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_val = exp_q.pop_front();
                checkOutput("spo", 64'(bus_if.spo), 64'(exp_val));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rc;
        rst       = 1'b1;
        bus_if.a  = 3'd0;
        bus_if.d  = 32'd0;
        bus_if.we = 1'b0;
        bus_if.rd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset values and STATUS read");
        checkOutput("reset_irq", 64'(irq), 64'd0);
        checkOutput("reset_ready", 64'(bus_if.ready), 64'd0);
        checkOutput("reset_spo", 64'(bus_if.spo), 64'd0);
        applyStimulus(MTIMER_STATUS, 32'd0, 1'b0, 1'b1, 32'd0);
        applyStimulus(MTIMER_CMP_LO, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(MTIMER_CTRL,   32'd0, 1'b0, 1'b1, 32'd0);

        $display("[TB] compare and interrupt");
        applyStimulus(MTIMER_CMP_LO, 32'd10, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_CMP_HI, 32'd0,  1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_CTRL,   32'd3,  1'b1, 1'b0, 32'd0);
        n = 0;
        while (!irq && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("irq_rise_cycle", 64'(n), 64'd9);
        applyStimulus(MTIMER_CMP_LO, 32'd1000, 1'b1, 1'b0, 32'd0);
        checkOutput("irq_before_fall", 64'(irq_at_ready), 64'd1);
        checkOutput("irq_after_cmp_raise", 64'(irq), 64'd0);
        applyStimulus(MTIMER_CTRL, 32'd0, 1'b1, 1'b0, 32'd0);

        $display("[TB] coherent 64-bit read across the wrap");
        applyStimulus(MTIMER_MTIME_LO, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_MTIME_HI, 32'd0, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_CTRL, 32'd1, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(MTIMER_MTIME_HI, 32'd0, 1'b0, 1'b1, 32'd0);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'd5);
        applyStimulus(MTIMER_MTIME_HI, 32'd0, 1'b0, 1'b1, 32'd1);
        checkOutput("irq_en_off", 64'(irq), 64'd0);

        $display("[TB] held read gives one ready");
        applyStimulus(MTIMER_CTRL, 32'd0, 1'b1, 1'b0, 32'd0);
        rc = ready_count;
        bus_if.a  = MTIMER_CMP_LO;
        bus_if.rd = 1'b1;
        exp_q.push_back(32'd1000);
        repeat (5) @(negedge clk);
        checkOutput("held_ready_pulses", 64'(ready_count - rc), 64'd1);
        checkOutput("held_state", 64'(dut.state), 64'(ST_HOLD));
        bus_if.rd = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_after_drop", 64'(dut.state), 64'(ST_IDLE));
        applyStimulus(MTIMER_CMP_LO, 32'd0, 1'b0, 1'b1, 32'd1000);

        $display("[TB] write+read together and write-wins");
        rc = ready_count;
        applyStimulus(MTIMER_CMP_LO, 32'd5, 1'b1, 1'b1, 32'd0);
        checkOutput("wr_rd_single_ready", 64'(ready_count - rc), 64'd1);
        applyStimulus(MTIMER_CMP_LO, 32'd0, 1'b0, 1'b1, 32'd5);
        applyStimulus(MTIMER_CTRL, 32'd1, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_MTIME_LO, 32'h100, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'h102);

        applyStimulus(MTIMER_RESERVED, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_RESERVED, 32'd0, 1'b0, 1'b1, 32'd0);
`ifdef MTIMER_PRESCALE_EN
        $display("[TB] prescaler");
        applyStimulus(MTIMER_CTRL,     32'd0, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_PRESCALE, 32'd3, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_MTIME_HI, 32'd0, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_CTRL,     32'd1, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'd0);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'd1);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'd2);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'd2);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'd3);
        applyStimulus(MTIMER_PRESCALE, 32'd0, 1'b0, 1'b1, 32'd3);
`else
        applyStimulus(MTIMER_PRESCALE, 32'h1234, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_PRESCALE, 32'd0, 1'b0, 1'b1, 32'd0);
`endif

        $display("[TB] reset in the middle of a transaction");
        applyStimulus(MTIMER_CMP_LO, 32'd0, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_CMP_HI, 32'd0, 1'b1, 1'b0, 32'd0);
        applyStimulus(MTIMER_CTRL,   32'd3, 1'b1, 1'b0, 32'd0);
        checkOutput("irq_set_before_reset", 64'(irq), 64'd1);
        bus_if.a  = MTIMER_CTRL;
        bus_if.rd = 1'b1;
        exp_q.push_back(32'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_ready", 64'(bus_if.ready), 64'd0);
        checkOutput("mid_reset_irq", 64'(irq), 64'd0);
        checkOutput("mid_reset_state", 64'(dut.state), 64'(ST_IDLE));
        @(negedge clk);
        rst       = 1'b0;
        bus_if.rd = 1'b0;
        @(negedge clk);
        applyStimulus(MTIMER_MTIME_HI, 32'd0, 1'b0, 1'b1, 32'd0);
        applyStimulus(MTIMER_MTIME_LO, 32'd0, 1'b0, 1'b1, 32'd0);
        applyStimulus(MTIMER_CMP_LO,   32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(MTIMER_CMP_HI,   32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(MTIMER_CTRL,     32'd0, 1'b0, 1'b1, 32'd0);
        applyStimulus(MTIMER_STATUS,   32'd0, 1'b0, 1'b1, 32'd0);
        applyStimulus(MTIMER_PRESCALE, 32'd0, 1'b0, 1'b1, 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
